// File: rtl/in_sa_row_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module   : in_sa_row_skew_feeder
// Purpose  : Row-side systolic-array feeder. A vector FIFO is popped once per
//            array-advance cycle into per-row diagonal skew chains.
// Revision : 1.0 - initial release
// ============================================================================
module in_sa_row_skew_feeder #(
    parameter int ROW     = 8,
    parameter int W_DATA  = 8,
    parameter int DEPTH   = 4,
    parameter int SKEW_EN = 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [W_DATA*ROW-1:0]        i_data,
    input  logic [ROW-1:0]               i_data_valid,
    input  logic                         i_vec_valid,
    output logic                         o_vec_ready,
    input  logic                         i_sa_en,
    output logic [(W_DATA+1)*ROW-1:0]    o_data,
    output logic [$clog2(DEPTH):0]       o_level,
    output logic                         o_idle
);

    localparam int               c_aw   = $clog2(DEPTH);
    localparam int               c_fw   = W_DATA + 1;
    localparam int               c_vw   = c_fw * ROW;
    localparam logic [c_aw:0]    c_full = (c_aw+1)'(DEPTH);

    logic [c_vw-1:0]   r_mem [0:DEPTH-1];
    logic [c_aw-1:0]   r_wr_ptr;
    logic [c_aw-1:0]   r_rd_ptr;
    logic [c_aw:0]     r_level;

    logic              w_push;
    logic              w_pop;
    logic [c_vw-1:0]   w_wr_vec;
    logic [c_vw-1:0]   w_rd_vec;
    logic [ROW-1:0]    w_row_busy;

    assign o_vec_ready = (r_level != c_full);
    assign w_push      = i_vec_valid && o_vec_ready;
    assign w_pop       = i_sa_en && (r_level != '0);
    assign w_rd_vec    = r_mem[r_rd_ptr];
    assign o_level     = r_level;
    assign o_idle      = (r_level == '0) && !(|w_row_busy);

    // Entries are stored already in output-field layout with masked data zeroed.
    always_comb begin
        w_wr_vec = '0;
        for (int i = 0; i < ROW; i++) begin
            w_wr_vec[c_fw*(ROW-i)-1 -: c_fw] =
                {i_data_valid[i],
                 i_data_valid[i] ? i_data[W_DATA*(ROW-i)-1 -: W_DATA] : {W_DATA{1'b0}}};
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wr_vec;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    generate
        for (genvar r = 0; r < ROW; r++) begin : g_row
            localparam int c_nst = (SKEW_EN != 0) ? r + 1 : 1;

            logic [c_fw-1:0] r_stage [0:c_nst-1];
            logic [c_fw-1:0] w_head;
            logic            w_busy;

            // An empty FIFO on an advance cycle feeds a bubble into the chain.
            assign w_head = w_pop ? w_rd_vec[c_fw*(ROW-r)-1 -: c_fw] : '0;

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    for (int k = 0; k < c_nst; k++) begin
                        r_stage[k] <= '0;
                    end
                end else if (i_sa_en) begin
                    r_stage[0] <= w_head;
                    for (int k = 1; k < c_nst; k++) begin
                        r_stage[k] <= r_stage[k-1];
                    end
                end
            end

            always_comb begin
                w_busy = 1'b0;
                for (int k = 0; k < c_nst; k++) begin
                    w_busy = w_busy | r_stage[k][W_DATA];
                end
            end

            assign w_row_busy[r]                    = w_busy;
            assign o_data[c_fw*(ROW-r)-1 -: c_fw]   = r_stage[c_nst-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_in_sa_row_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_in_sa_row_skew_feeder
// Purpose  : Directed bench for the row skew feeder (skewed and unskewed builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_in_sa_row_skew_feeder;

    typedef struct {
        logic        rst;
        logic        vv;
        logic        sa;
        logic [63:0] data;
        logic [7:0]  mask;
        logic [2:0]  lvl;
        logic        rdy;
        logic        idle;
        logic [71:0] d1;
        logic [71:0] d0;
    } vec_t;

    logic        clk;
    logic        r_rst;
    logic [63:0] r_data;
    logic [7:0]  r_mask;
    logic        r_vv;
    logic        r_sa;

    logic        w_rdy1, w_rdy0, w_idle1, w_idle0;
    logic [71:0] w_data1, w_data0;
    logic [2:0]  w_lvl1, w_lvl0;

    int n_chk;
    int n_err;
    vec_t tbl[$];

    in_sa_row_skew_feeder #(.ROW(8), .W_DATA(8), .DEPTH(4), .SKEW_EN(1)) u_dut1 (
        .i_clk(clk), .i_rst(r_rst), .i_data(r_data), .i_data_valid(r_mask),
        .i_vec_valid(r_vv), .o_vec_ready(w_rdy1), .i_sa_en(r_sa),
        .o_data(w_data1), .o_level(w_lvl1), .o_idle(w_idle1)
    );

    in_sa_row_skew_feeder #(.ROW(8), .W_DATA(8), .DEPTH(4), .SKEW_EN(0)) u_dut0 (
        .i_clk(clk), .i_rst(r_rst), .i_data(r_data), .i_data_valid(r_mask),
        .i_vec_valid(r_vv), .o_vec_ready(w_rdy0), .i_sa_en(r_sa),
        .o_data(w_data0), .o_level(w_lvl0), .o_idle(w_idle0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [71:0] put(int r, logic v, logic [7:0] d);
        logic [71:0] x;
        x = '0;
        x[9*(8-r)-1 -: 9] = {v, d};
        return x;
    endfunction

    function automatic logic [63:0] vdat(logic [7:0] b);
        logic [63:0] x;
        x = '0;
        for (int i = 0; i < 8; i++) x[8*(8-i)-1 -: 8] = b + 8'(i);
        return x;
    endfunction

    // Every row presented on the same cycle, as the unskewed build shows it.
    function automatic logic [71:0] allrows(logic [63:0] d, logic [7:0] m);
        logic [71:0] x;
        x = '0;
        for (int r = 0; r < 8; r++)
            x[9*(8-r)-1 -: 9] = {m[r], m[r] ? d[8*(8-r)-1 -: 8] : 8'h00};
        return x;
    endfunction

    task automatic add(logic rst, logic vv, logic sa, logic [63:0] data, logic [7:0] mask,
                       logic [2:0] lvl, logic rdy, logic idle, logic [71:0] d1, logic [71:0] d0);
        vec_t v;
        v.rst = rst; v.vv = vv; v.sa = sa; v.data = data; v.mask = mask;
        v.lvl = lvl; v.rdy = rdy; v.idle = idle; v.d1 = d1; v.d0 = d0;
        tbl.push_back(v);
    endtask

    task automatic chk(string name, int idx, logic [71:0] act, logic [71:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] d1v, dmv, dsv;
        logic [7:0]  bases [0:5];
        n_chk = 0;
        n_err = 0;
        r_rst = 1'b1; r_vv = 1'b0; r_sa = 1'b1; r_data = '0; r_mask = '0;

        d1v = vdat(8'h01);
        dmv = 64'hFFFF_FFFF_FFFF_FFFF;
        dsv = vdat(8'hA0);

        // Reset then idle
        add(1,0,1,'0,'0, 3'd0,1,1, '0,'0);
        add(1,0,1,'0,'0, 3'd0,1,1, '0,'0);
        // Single fully valid vector
        add(0,1,1,d1v,8'hFF, 3'd1,1,0, '0,'0);
        add(0,0,1,'0,'0, 3'd0,1,0, put(0,1,8'h01), allrows(d1v,8'hFF));
        for (int r = 1; r < 8; r++)
            add(0,0,1,'0,'0, 3'd0,1,0, put(r,1,8'(r+1)), '0);
        add(0,0,1,'0,'0, 3'd0,1,1, '0,'0);
        // Masked rows: only rows 0-3 valid
        add(0,1,1,dmv,8'h0F, 3'd1,1,0, '0,'0);
        add(0,0,1,'0,'0, 3'd0,1,0, put(0,1,8'hFF), allrows(dmv,8'h0F));
        for (int r = 1; r < 4; r++)
            add(0,0,1,'0,'0, 3'd0,1,0, put(r,1,8'hFF), '0);
        for (int r = 4; r < 8; r++)
            add(0,0,1,'0,'0, 3'd0,1,1, '0,'0);
        // Stall mid-skew after two shifts
        add(0,1,1,dsv,8'hFF, 3'd1,1,0, '0,'0);
        add(0,0,1,'0,'0, 3'd0,1,0, put(0,1,8'hA0), allrows(dsv,8'hFF));
        add(0,0,1,'0,'0, 3'd0,1,0, put(1,1,8'hA1), '0);
        for (int s = 0; s < 3; s++)
            add(0,0,0,'0,'0, 3'd0,1,0, put(1,1,8'hA1), '0);
        for (int r = 2; r < 8; r++)
            add(0,0,1,'0,'0, 3'd0,1,0, put(r,1,8'hA0 + 8'(r)), '0);
        add(0,0,1,'0,'0, 3'd0,1,1, '0,'0);
        // Reset with three vectors queued and one in the chain
        add(0,1,1,vdat(8'h40),8'hFF, 3'd1,1,0, '0,'0);
        add(0,1,1,vdat(8'h50),8'hFF, 3'd1,1,0, put(0,1,8'h40), allrows(vdat(8'h40),8'hFF));
        add(0,1,0,vdat(8'h60),8'hFF, 3'd2,1,0, put(0,1,8'h40), allrows(vdat(8'h40),8'hFF));
        add(0,1,0,vdat(8'h70),8'hFF, 3'd3,1,0, put(0,1,8'h40), allrows(vdat(8'h40),8'hFF));
        add(1,1,1,vdat(8'h80),8'hFF, 3'd0,1,1, '0,'0);
        for (int s = 0; s < 10; s++)
            add(0,0,1,'0,'0, 3'd0,1,1, '0,'0);

        for (int i = 0; i < tbl.size(); i++) begin
            r_rst  = tbl[i].rst;
            r_vv   = tbl[i].vv;
            r_sa   = tbl[i].sa;
            r_data = tbl[i].data;
            r_mask = tbl[i].mask;
            tick();
            chk("data_skew",   i, w_data1, tbl[i].d1);
            chk("data_noskew", i, w_data0, tbl[i].d0);
            chk("level",       i, 72'(w_lvl1), 72'(tbl[i].lvl));
            chk("level_noskew",i, 72'(w_lvl0), 72'(tbl[i].lvl));
            chk("ready",       i, 72'(w_rdy1), 72'(tbl[i].rdy));
            chk("ready_noskew",i, 72'(w_rdy0), 72'(tbl[i].rdy));
            chk("idle",        i, 72'(w_idle1), 72'(tbl[i].idle));
        end

        // Backpressure: six offers while stalled, only four fit
        bases[0] = 8'h10; bases[1] = 8'h20; bases[2] = 8'h30;
        bases[3] = 8'h40; bases[4] = 8'h50; bases[5] = 8'h60;
        r_rst = 1'b0; r_sa = 1'b0; r_mask = 8'hFF;
        for (int k = 0; k < 6; k++) begin
            r_vv   = 1'b1;
            r_data = vdat(bases[k]);
            tick();
            chk("bp_fill_level", k, 72'(w_lvl1), 72'((k < 4) ? k + 1 : 4));
            chk("bp_fill_ready", k, 72'(w_rdy1), 72'(k < 3));
            chk("bp_fill_idle0", k, 72'(w_idle0), 72'(0));
        end
        r_vv = 1'b0;
        r_sa = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick();
            chk("bp_drain_level", j, 72'(w_lvl1), 72'(3 - j));
            chk("bp_drain_ready", j, 72'(w_rdy1), 72'(1));
            chk("bp_drain_row0",  j, 72'(w_data1[71:63]), 72'({1'b1, bases[j]}));
        end
        r_vv = 1'b1; r_data = vdat(bases[4]);
        tick();
        chk("bp_nobypass_level", 0, 72'(w_lvl1), 72'(1));
        chk("bp_nobypass_row0",  0, 72'(w_data1[71:63]), 72'(0));
        r_data = vdat(bases[5]);
        tick();
        chk("bp_tail_level", 0, 72'(w_lvl1), 72'(1));
        chk("bp_tail_row0",  0, 72'(w_data1[71:63]), 72'({1'b1, bases[4]}));
        r_vv = 1'b0;
        tick();
        chk("bp_tail_level", 1, 72'(w_lvl1), 72'(0));
        chk("bp_tail_row0",  1, 72'(w_data1[71:63]), 72'({1'b1, bases[5]}));
        for (int s = 0; s < 8; s++) tick();
        chk("bp_end_idle",  0, 72'(w_idle1), 72'(1));
        chk("bp_end_idle0", 0, 72'(w_idle0), 72'(1));
        chk("bp_end_data",  0, w_data1, 72'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
